// File: rtl/tmds_pkg.sv
// tmds_pkg
// Shared constants for the TMDS transmit path.
//   TMDS_SYM_W      : width of one TMDS symbol (10 bits).
//   CTRL_00..CTRL_11: the four TMDS control-period symbols, indexed by {C1,C0}.
//   cnt_w()         : width of a counter that must hold 0..n-1. It never
//                     returns less than 1.
package tmds_pkg;

  localparam int TMDS_SYM_W = 10;

  localparam logic [TMDS_SYM_W-1:0] CTRL_00 = 10'b1101010100;
  localparam logic [TMDS_SYM_W-1:0] CTRL_01 = 10'b0010101011;
  localparam logic [TMDS_SYM_W-1:0] CTRL_10 = 10'b0101010100;
  localparam logic [TMDS_SYM_W-1:0] CTRL_11 = 10'b1010101011;

  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serializer_10to1_mod_counter.sv
// mod_counter
// Free-running modulo-MOD counter. It advances on every clock outside reset.
//   i_clk      : clock; the counter updates on the rising edge
//   i_rst_n    : synchronous active-low reset; forces the count to 0
//   o_wrapped  : high while the count is 0, that is, after reset or after the
//                count wraps from MOD-1 back to 0
module mod_counter
  import tmds_pkg::*;
#(
  parameter int MOD = 10
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_wrapped
);

  localparam int W = cnt_w(MOD);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!i_rst_n) begin
      cnt_d = '0;
    end else if (cnt_q == W'(MOD - 1)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    cnt_q <= cnt_d;
  end

  assign o_wrapped = (cnt_q == '0);

endmodule

// File: rtl/serializer_10to1.sv
// serializer_10to1
// Parallel-to-serial converter for one TMDS channel. One DATA_W-bit symbol is
// captured every DATA_W clocks. The symbol is shifted out one bit per clock,
// so o_data is a continuous bitstream with no idle bits between symbols.
//   i_clk    : bit-rate clock; all logic uses the rising edge
//   i_rst_n  : synchronous active-low reset. It clears all state, and any
//              symbol in flight is dropped.
//   i_data   : parallel symbol. It is sampled only on the edge that closes a
//              cycle with o_load high.
//   o_load   : high in the cycle whose closing edge samples i_data
//   o_data   : registered serial bit. Bit j of a symbol captured at edge E is
//              driven from edge E+j.
// MSB_FIRST=0 sends bit 0 first. MSB_FIRST=1 sends bit DATA_W-1 first.
module serializer_10to1
  import tmds_pkg::*;
#(
  parameter int DATA_W    = TMDS_SYM_W,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_load,
  output logic              o_data
);

  logic              at_zero;
  logic [DATA_W-1:0] shreg_q;
  logic [DATA_W-1:0] shreg_d;
  logic              data_q;
  logic              data_d;

  // The bit counter wraps every DATA_W clocks. A count of 0 marks the load slot.
  mod_counter #(
    .MOD (DATA_W)
  ) u_bit_cnt (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .o_wrapped (at_zero)
  );

  // The first bit of a symbol goes to the output register straight from
  // i_data. Only the remaining bits are parked in shreg, so the stream has
  // no gap at symbol boundaries.
  always_comb begin
    shreg_d = shreg_q;
    data_d  = data_q;
    if (!i_rst_n) begin
      shreg_d = '0;
      data_d  = 1'b0;
    end else if (at_zero) begin
      if (MSB_FIRST) begin
        data_d  = i_data[DATA_W-1];
        shreg_d = i_data << 1;
      end else begin
        data_d  = i_data[0];
        shreg_d = i_data >> 1;
      end
    end else begin
      if (MSB_FIRST) begin
        data_d  = shreg_q[DATA_W-1];
        shreg_d = shreg_q << 1;
      end else begin
        data_d  = shreg_q[0];
        shreg_d = shreg_q >> 1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    shreg_q <= shreg_d;
    data_q  <= data_d;
  end

  // o_load is gated by the reset pin, so it reads 0 throughout reset.
  // It reads 1 as soon as reset is released.
  assign o_load = at_zero && i_rst_n;
  assign o_data = data_q;

endmodule

// File: tb/tb_serializer_10to1.sv
// Bench for serializer_10to1. One LSB-first instance and one MSB-first
// instance share the same inputs. A queue-based model predicts both bitstreams.
module tb_serializer_10to1;
  import tmds_pkg::*;

  localparam int W = TMDS_SYM_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         i_rst_n;
  logic [W-1:0] i_data;
  logic         lsb_load, lsb_data;
  logic         msb_load, msb_data;

  serializer_10to1 #(.DATA_W(W), .MSB_FIRST(1'b0)) dut_lsb (
    .i_clk   (clk),
    .i_rst_n (i_rst_n),
    .i_data  (i_data),
    .o_load  (lsb_load),
    .o_data  (lsb_data)
  );

  serializer_10to1 #(.DATA_W(W), .MSB_FIRST(1'b1)) dut_msb (
    .i_clk   (clk),
    .i_rst_n (i_rst_n),
    .i_data  (i_data),
    .o_load  (msb_load),
    .o_data  (msb_data)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
  endtask

  // Model: each queue holds the bits of the current symbol that have not
  // been sent yet. An empty queue outside reset means the next edge loads
  // a new symbol.
  logic exp_q_lsb[$];
  logic exp_q_msb[$];
  logic exp_lsb = 1'b0;
  logic exp_msb = 1'b0;
  bit   model_live = 1'b0;

  always @(posedge clk) begin
    if (i_rst_n === 1'b0) begin
      exp_q_lsb.delete();
      exp_q_msb.delete();
      exp_lsb    = 1'b0;
      exp_msb    = 1'b0;
      model_live = 1'b1;
    end else if (model_live) begin
      if (exp_q_lsb.size() == 0) begin
        for (int j = 0; j < W; j++) begin
          exp_q_lsb.push_back(i_data[j]);
          exp_q_msb.push_back(i_data[W-1-j]);
        end
      end
      exp_lsb = exp_q_lsb.pop_front();
      exp_msb = exp_q_msb.pop_front();
    end
  end

  // Compare process: checks every cycle after the first reset edge.
  always @(negedge clk) begin
    if (model_live) begin
      check("model_lsb_data", lsb_data, exp_lsb);
      check("model_msb_data", msb_data, exp_msb);
      check("model_lsb_load", lsb_load, (exp_q_lsb.size() == 0) && (i_rst_n === 1'b1));
      check("model_msb_load", msb_load, (exp_q_msb.size() == 0) && (i_rst_n === 1'b1));
    end
  end

  // ---------------- driver tasks ----------------
  // Each task is called at posedge+2. It applies the inputs and then checks
  // o_load before the edge. After the edge it checks o_data against
  // hand-computed literals.
  task automatic drive(input string name, input logic rst, input logic [W-1:0] d,
                       input logic exp_load, input logic exp_l, input logic exp_m);
    i_rst_n = rst;
    i_data  = d;
    #1;
    check({name, "_load_lsb"}, lsb_load, exp_load);
    check({name, "_load_msb"}, msb_load, exp_load);
    @(posedge clk);
    #1;
    check({name, "_bit_lsb"}, lsb_data, exp_l);
    check({name, "_bit_msb"}, msb_data, exp_m);
    #1;
  endtask

  // st_l and st_m list the expected stream, with the first bit on the left.
  task automatic send(input string name, input logic [W-1:0] sym,
                      input logic [0:W-1] st_l, input logic [0:W-1] st_m, input bit scramble);
    logic [W-1:0] d;
    for (int k = 0; k < W; k++) begin
      d = sym;
      if (scramble && k >= 3 && k <= 8) d = W'($urandom_range(0, (1 << W) - 1));
      drive(name, 1'b1, d, (k == 0), st_l[k], st_m[k]);
    end
  endtask

  task automatic raw(input logic rst, input logic [W-1:0] d);
    i_rst_n = rst;
    i_data  = d;
    @(posedge clk);
    #2;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset hold with all-ones data on the input.
    for (int i = 0; i < 3; i++) drive("rst_hold", 1'b0, 10'h3FF, 1'b0, 1'b0, 1'b0);

    // Single symbol, followed directly by two back-to-back symbols.
    send("single", 10'b0110100110, 10'b0110010110, 10'b0110100110, 1'b0);
    send("b2b_a",  10'b1001011001, 10'b1001101001, 10'b1001011001, 1'b0);
    send("b2b_b",  10'b1100000010, 10'b0100000011, 10'b1100000010, 1'b0);

    // Input data changes on cycles 3..8 of the symbol.
    send("midchg", 10'b1010101010, 10'b0101010101, 10'b1010101010, 1'b1);

    // Reset at bit 4. Bits 0..3 go out, then the reset edge, then a fresh load.
    drive("pre_rst", 1'b1, 10'b0110100110, 1'b1, 1'b0, 1'b0);
    drive("pre_rst", 1'b1, 10'h155,        1'b0, 1'b1, 1'b1);
    drive("pre_rst", 1'b1, 10'h2AA,        1'b0, 1'b1, 1'b1);
    drive("pre_rst", 1'b1, 10'h0F0,        1'b0, 1'b0, 1'b0);
    drive("mid_rst", 1'b0, 10'h3FF,        1'b0, 1'b0, 1'b0);
    send("post_rst", CTRL_00, 10'b0010101011, 10'b1101010100, 1'b0);

    // Random data, with occasional reset pulses.
    for (int i = 0; i < 400; i++) begin
      raw(($urandom_range(0, 39) != 0), W'($urandom_range(0, (1 << W) - 1)));
    end
    for (int i = 0; i < 3 * W; i++) raw(1'b1, W'($urandom_range(0, (1 << W) - 1)));

    @(posedge clk);
    #6;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
